// File: rtl/tri_vertex_animator_if.sv
// Bus between the raster timing/consumer side and the triangle vertex animator:
// pixel counters and pause in, committed vertex coordinates and update pulse out.
interface tri_vertex_animator_if;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic        pause;
    logic [10:0] x0, x1, x2;
    logic [9:0]  y0, y1, y2;
    logic        upd;

    modport master (
        output cx, cy, pause,
        input  x0, x1, x2, y0, y1, y2, upd
    );

    modport slave (
        input  cx, cy, pause,
        output x0, x1, x2, y0, y1, y2, upd
    );
endinterface

// File: rtl/tri_vertex_animator.sv
// Moves three triangle vertices once per frame with wall bounces; results are committed atomically.
// Optional macro TRI_ANIM_FRAME_DIV_EN: update only every FRAME_DIV non-paused frames.
module tri_vertex_animator #(
    parameter int H_LAST  = 1585,
    parameter int V_LAST  = 525,
    parameter int XMIN    = 0,
    parameter int XMAX    = 1269,
    parameter int YMIN    = 0,
    parameter int YMAX    = 479,
    parameter int STEP_X  = 4,
    parameter int STEP_Y  = 2,
    parameter int X0_INIT = 300,
    parameter int Y0_INIT = 300,
    parameter int X1_INIT = 1000,
    parameter int Y1_INIT = 100,
    parameter int X2_INIT = 600,
`ifdef TRI_ANIM_FRAME_DIV_EN
    parameter int Y2_INIT = 450,
    parameter int FRAME_DIV = 2
`else
    parameter int Y2_INIT = 450
`endif
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    tri_vertex_animator_if.slave  bus
);

    localparam logic [11:0] XLO = 12'(XMIN);
    localparam logic [11:0] XHI = 12'(XMAX);
    localparam logic [11:0] YLO = 12'(YMIN);
    localparam logic [11:0] YHI = 12'(YMAX);
    localparam logic [11:0] SX  = 12'(STEP_X);
    localparam logic [11:0] SY  = 12'(STEP_Y);

    typedef enum logic [2:0] {S_WAIT, S_V0, S_V1, S_V2, S_COMMIT} state_t;

    state_t      state;
    logic [11:0] wx0, wy0, wx1, wy1, wx2, wy2;
    logic        dx0, dy0, dx1, dy1, dx2, dy2;   // 1 = moving toward MAX
    logic [10:0] ox0, ox1, ox2;
    logic [9:0]  oy0, oy1, oy2;
    logic        upd_r;
    logic        eof;

    // Returns {new_dir, new_pos}. Clamps to the bound and flips only when the
    // step would overshoot; an exact landing on the bound keeps the direction.
    function automatic logic [12:0] bounce(input logic [11:0] p, input logic dir_pos,
                                           input logic [11:0] step, input logic [11:0] lo,
                                           input logic [11:0] hi);
        logic [12:0] r;
        if (dir_pos) begin
            if (p + step > hi) r = {1'b0, hi};
            else               r = {1'b1, p + step};
        end else begin
            if (p < lo + step) r = {1'b1, lo};
            else               r = {1'b0, p - step};
        end
        return r;
    endfunction

    assign eof = (bus.cx == 11'(H_LAST)) && (bus.cy == 10'(V_LAST));

`ifdef TRI_ANIM_FRAME_DIV_EN
    logic [7:0] fcnt;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_WAIT;
            upd_r <= 1'b0;
            wx0 <= 12'(X0_INIT); wy0 <= 12'(Y0_INIT);
            wx1 <= 12'(X1_INIT); wy1 <= 12'(Y1_INIT);
            wx2 <= 12'(X2_INIT); wy2 <= 12'(Y2_INIT);
            dx0 <= 1'b1; dy0 <= 1'b1;
            dx1 <= 1'b0; dy1 <= 1'b1;
            dx2 <= 1'b1; dy2 <= 1'b0;
            ox0 <= 11'(X0_INIT); oy0 <= 10'(Y0_INIT);
            ox1 <= 11'(X1_INIT); oy1 <= 10'(Y1_INIT);
            ox2 <= 11'(X2_INIT); oy2 <= 10'(Y2_INIT);
`ifdef TRI_ANIM_FRAME_DIV_EN
            fcnt <= 8'd0;
`endif
        end else begin
            upd_r <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (eof && !bus.pause) begin
`ifdef TRI_ANIM_FRAME_DIV_EN
                        if (fcnt == 8'(FRAME_DIV - 1)) begin
                            fcnt  <= 8'd0;
                            state <= S_V0;
                        end else begin
                            fcnt <= fcnt + 8'd1;
                        end
`else
                        state <= S_V0;
`endif
                    end
                end
                S_V0: begin
                    {dx0, wx0} <= bounce(wx0, dx0, SX, XLO, XHI);
                    {dy0, wy0} <= bounce(wy0, dy0, SY, YLO, YHI);
                    state <= S_V1;
                end
                S_V1: begin
                    {dx1, wx1} <= bounce(wx1, dx1, SX, XLO, XHI);
                    {dy1, wy1} <= bounce(wy1, dy1, SY, YLO, YHI);
                    state <= S_V2;
                end
                S_V2: begin
                    {dx2, wx2} <= bounce(wx2, dx2, SX, XLO, XHI);
                    {dy2, wy2} <= bounce(wy2, dy2, SY, YLO, YHI);
                    state <= S_COMMIT;
                end
                S_COMMIT: begin
                    // Working values are always inside the bounds, so the narrower
                    // output registers lose nothing.
                    ox0 <= wx0[10:0]; oy0 <= wy0[9:0];
                    ox1 <= wx1[10:0]; oy1 <= wy1[9:0];
                    ox2 <= wx2[10:0]; oy2 <= wy2[9:0];
                    upd_r <= 1'b1;
                    state <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    assign bus.x0  = ox0;
    assign bus.y0  = oy0;
    assign bus.x1  = ox1;
    assign bus.y1  = oy1;
    assign bus.x2  = ox2;
    assign bus.y2  = oy2;
    assign bus.upd = upd_r;

endmodule

// File: tb/tb_tri_vertex_animator.sv
// Directed, table-driven bench for tri_vertex_animator: a default instance plus a
// second instance with start positions near the walls to exercise bounces.
module tb_tri_vertex_animator;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   total    = 0;
    int   bad      = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    tri_vertex_animator_if ifa ();
    tri_vertex_animator_if ifb ();

    tri_vertex_animator dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (ifa.slave)
    );

    tri_vertex_animator #(
        .X0_INIT (1267),
        .Y0_INIT (477),
        .Y2_INIT (1)
    ) dut_b (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (ifb.slave)
    );

    typedef struct {
        logic p;
        logic u;
        int   x0, y0, x1, y1, x2, y2;
        int   bx0, by0, by2;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive(input int cx, input int cy, input logic p);
        ifa.cx = 11'(cx); ifa.cy = 10'(cy); ifa.pause = p;
        ifb.cx = 11'(cx); ifb.cy = 10'(cy); ifb.pause = p;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, "_upd"}, int'(ifa.upd), int'(v.u));
        chk({tag, "_x0"}, int'(ifa.x0), v.x0);
        chk({tag, "_y0"}, int'(ifa.y0), v.y0);
        chk({tag, "_x1"}, int'(ifa.x1), v.x1);
        chk({tag, "_y1"}, int'(ifa.y1), v.y1);
        chk({tag, "_x2"}, int'(ifa.x2), v.x2);
        chk({tag, "_y2"}, int'(ifa.y2), v.y2);
        chk({tag, "_b_upd"}, int'(ifb.upd), int'(v.u));
        chk({tag, "_b_x0"}, int'(ifb.x0), v.bx0);
        chk({tag, "_b_y0"}, int'(ifb.y0), v.by0);
        chk({tag, "_b_y2"}, int'(ifb.y2), v.by2);
    endtask

    // One eof cycle; leaves the DUT one edge past the eof sample.
    task automatic eof_edge(input logic p);
        drive(1585, 525, p);
        tick();
        drive(0, 0, p);
    endtask

    // With the frame divider built in, a lone non-paused eof must not update.
    task automatic pre_eof();
`ifdef TRI_ANIM_FRAME_DIV_EN
        int x0_before;
        x0_before = int'(ifa.x0);
        eof_edge(1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("div_skip_upd", int'(ifa.upd), 0);
        end
        chk("div_skip_x0", int'(ifa.x0), x0_before);
`endif
    endtask

    task automatic run_row(input string tag, input vec_t v);
        if (!v.p) pre_eof();
        eof_edge(v.p);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk({tag, "_early_upd"}, int'(ifa.upd), 0);
        end
        tick();
        check_out(tag, v);
        tick();
        chk({tag, "_upd_width"}, int'(ifa.upd), 0);
    endtask

    initial begin
        int   n_upd;
        vec_t init_v;
        vec_t v;

        init_v  = '{1'b0, 1'b0, 300, 300, 1000, 100, 600, 450, 1267, 477, 1};
        tbl[0]  = '{1'b0, 1'b1, 304, 302, 996, 102, 604, 448, 1269, 479, 0};
        tbl[1]  = '{1'b0, 1'b1, 308, 304, 992, 104, 608, 446, 1265, 479, 2};
        tbl[2]  = '{1'b1, 1'b0, 308, 304, 992, 104, 608, 446, 1265, 479, 2};
        tbl[3]  = '{1'b1, 1'b0, 308, 304, 992, 104, 608, 446, 1265, 479, 2};
        tbl[4]  = '{1'b1, 1'b0, 308, 304, 992, 104, 608, 446, 1265, 479, 2};
        tbl[5]  = '{1'b0, 1'b1, 312, 306, 988, 106, 612, 444, 1261, 477, 4};

        drive(0, 0, 1'b0);
        reset = 1'b1;
        repeat (3) tick();
        check_out("reset", init_v);
        reset = 1'b0;
        tick();
        check_out("after_reset", init_v);

        // Counters sweep but the last line is never reached.
        n_upd = 0;
        for (int i = 0; i < 10000; i++) begin
            drive(i % 1586, (i / 1586) % 525, 1'b0);
            tick();
            if (ifa.upd || ifb.upd) n_upd++;
        end
        drive(1585, 0, 1'b0);
        tick();
        if (ifa.upd || ifb.upd) n_upd++;
        drive(0, 0, 1'b0);
        chk("idle_upd_count", n_upd, 0);
        check_out("idle", init_v);

        for (int r = 0; r < 6; r++) begin
            run_row($sformatf("row%0d", r), tbl[r]);
        end

        // Pause raised while the FSM is in S_V1: the sequence still commits.
        pre_eof();
        eof_edge(1'b0);
        tick();
        drive(0, 0, 1'b1);
        tick();
        chk("pmid_early_upd", int'(ifa.upd), 0);
        tick();
        chk("pmid_early_upd2", int'(ifa.upd), 0);
        tick();
        v = '{1'b0, 1'b1, 316, 308, 984, 108, 616, 442, 1257, 475, 6};
        check_out("pause_mid", v);
        drive(0, 0, 1'b0);
        tick();

        // Reset while in S_V2 aborts the sequence without a pulse.
        pre_eof();
        eof_edge(1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_out("reset_v2", init_v);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("reset_v2_no_upd", int'(ifa.upd), 0);
        end
        chk("reset_v2_x0_hold", int'(ifa.x0), 300);

        run_row("post_reset", tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
